// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg: shared state encoding and default widths for the DDS sweep sequencer.
package dds_sweep_pkg;
  localparam int DDS_PHASE_WIDTH = 32;
  localparam int DDS_DWELL_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } state_t;
endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: loadable down-counter; expired is high while the count is zero.
module sweep_dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int DWELL_WIDTH = DDS_DWELL_WIDTH
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] value,
  input  logic                   en,
  output logic                   expired
);
  logic [DWELL_WIDTH-1:0] r_cnt;
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) r_cnt <= '0;
    else if (load) r_cnt <= value;
    else if (en && r_cnt != '0) r_cnt <= r_cnt - DWELL_WIDTH'(1);
  assign expired = r_cnt == '0;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS frequency word from start to stop with a per-word dwell.
// DDS_SWEEP_PINGPONG_EN selects up/down bouncing instead of the default sawtooth.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
  parameter int DWELL_WIDTH = DDS_DWELL_WIDTH
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_continuous,
  input  logic [PHASE_WIDTH-1:0] cfg_start_word,
  input  logic [PHASE_WIDTH-1:0] cfg_stop_word,
  input  logic [PHASE_WIDTH-1:0] cfg_step_word,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [PHASE_WIDTH-1:0] cfg_pha_word,
  output logic                   dds_en,
  output logic [PHASE_WIDTH-1:0] fre_word,
  output logic [PHASE_WIDTH-1:0] pha_word,
  output logic                   busy,
  output logic                   done
);
  state_t                 r_state, w_state;
  logic                   r_cont, r_en, w_en, r_done, w_done;
  logic [PHASE_WIDTH-1:0] r_startw, r_stopw, r_step, r_fre, w_fre, r_pha;
  logic [DWELL_WIDTH-1:0] r_dwell, w_load_val;
  logic                   w_latch, w_load, w_tick, w_expired, w_up_ok;
  logic [PHASE_WIDTH:0]   w_up;
`ifdef DDS_SWEEP_PINGPONG_EN
  logic                   r_dir, w_dir, w_dn_ok;
  logic [PHASE_WIDTH:0]   w_dn;
  assign w_dn    = {1'b0, r_fre} - {1'b0, r_step};
  assign w_dn_ok = !w_dn[PHASE_WIDTH] && w_dn[PHASE_WIDTH-1:0] >= r_startw;
`endif
  // one extra bit so an overflowing step can never wrap below the stop word
  assign w_up       = {1'b0, r_fre} + {1'b0, r_step};
  assign w_up_ok    = w_up <= {1'b0, r_stopw};
  assign w_load_val = r_state == IDLE ? cfg_dwell : r_dwell;
  sweep_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_timer (
    .clock  (clock),
    .rstn   (rstn),
    .load   (w_load),
    .value  (w_load_val),
    .en     (w_tick),
    .expired(w_expired)
  );
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_state;
  always_comb begin
    w_state = r_state;
    w_fre   = r_fre;
    w_en    = r_en;
    w_done  = 1'b0;
    w_latch = 1'b0;
    w_load  = 1'b0;
    w_tick  = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
    w_dir   = r_dir;
`endif
    if (stop) begin
      w_state = IDLE;
      w_en    = 1'b0;
    end else case (r_state)
      IDLE: if (start) begin
        w_latch = 1'b1;
        w_load  = 1'b1;
        w_fre   = cfg_start_word;
        w_en    = 1'b1;
        w_state = DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
        w_dir   = 1'b0;
`endif
      end
      DWELL: if (w_expired) w_state = STEP;
        else w_tick = 1'b1;
      STEP: begin
        w_load  = 1'b1;
        w_state = DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
        if (!r_dir && w_up_ok) w_fre = w_up[PHASE_WIDTH-1:0];
        else if (w_dn_ok && r_step != '0) begin
          w_dir = 1'b1;
          w_fre = w_dn[PHASE_WIDTH-1:0];
        end else if (r_cont) begin
          w_dir = 1'b0;
          w_fre = w_up_ok ? w_up[PHASE_WIDTH-1:0] : r_startw;
        end else begin
          w_dir   = 1'b0;
          w_load  = 1'b0;
          w_done  = 1'b1;
          w_en    = 1'b0;
          w_state = IDLE;
        end
`else
        if (w_up_ok) w_fre = w_up[PHASE_WIDTH-1:0];
        else if (r_cont) w_fre = r_startw;
        else begin
          w_load  = 1'b0;
          w_done  = 1'b1;
          w_en    = 1'b0;
          w_state = IDLE;
        end
`endif
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) begin
      r_fre  <= '0;
      r_en   <= 1'b0;
      r_done <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
      r_dir  <= 1'b0;
`endif
    end else begin
      r_fre  <= w_fre;
      r_en   <= w_en;
      r_done <= w_done;
`ifdef DDS_SWEEP_PINGPONG_EN
      r_dir  <= w_dir;
`endif
    end
  // configuration shadows: frozen from start until the next start
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) begin
      r_cont   <= 1'b0;
      r_startw <= '0;
      r_stopw  <= '0;
      r_step   <= '0;
      r_dwell  <= '0;
      r_pha    <= '0;
    end else if (w_latch) begin
      r_cont   <= cfg_continuous;
      r_startw <= cfg_start_word;
      r_stopw  <= cfg_stop_word;
      r_step   <= cfg_step_word;
      r_dwell  <= cfg_dwell;
      r_pha    <= cfg_pha_word;
    end
  assign dds_en   = r_en;
  assign fre_word = r_fre;
  assign pha_word = r_pha;
  assign busy     = r_state != IDLE;
  assign done     = r_done;
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the sine DDS. It steps the DDS frequency control word from a start word to a stop word in fixed increments, holding each word for a programmable dwell time. It sits between the register/control logic and the DDS core, and drives the DDS enable, frequency word and phase word. It also supports single-shot and continuous (repeating) sweeps with an abort input.

## Interface
- PHASE_WIDTH, 32, width of the frequency and phase words; must match the DDS core.
- DWELL_WIDTH, 16, width of the dwell counter.

- clock  in  1  system clock; all logic is rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep; ignored unless IDLE.
- stop  in  1  single-cycle abort; returns to IDLE from any state.
- cfg_continuous  in  1  1 = restart the sweep at the end; 0 = single shot.
- cfg_start_word  in  PHASE_WIDTH  first frequency word.
- cfg_stop_word  in  PHASE_WIDTH  upper bound of the frequency word.
- cfg_step_word  in  PHASE_WIDTH  increment per step.
- cfg_dwell  in  DWELL_WIDTH  each word is held cfg_dwell+1 cycles.
- cfg_pha_word  in  PHASE_WIDTH  phase offset passed to the DDS.
- dds_en  out  1  DDS output enable.
- fre_word  out  PHASE_WIDTH  frequency word to the DDS.
- pha_word  out  PHASE_WIDTH  phase word to the DDS.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a single-shot sweep completes.

## Operation
- States:
  - IDLE: waiting for start.
  - DWELL: counting down the hold time.
  - STEP: advancing to the next word.
  - Encoding is defined in the package.
- Reset values: all outputs 0; state = IDLE; internal config shadows = 0.
- Start in IDLE:
  - All cfg_* inputs are latched into shadow registers.
  - fre_word = start word, pha_word = cfg_pha_word, dds_en = 1.
  - The dwell counter is loaded with cfg_dwell; next state = DWELL.
  - cfg_* changes after this point have no effect until the next start.
- DWELL: the counter decrements each cycle; at 0 the block moves to STEP.
- STEP: computes next = fre_word + step in PHASE_WIDTH+1 bits. No wrap-around is permitted.
  - If next <= stop_word: fre_word = next, reload the counter, go to DWELL.
  - Else, with continuous set: fre_word = start_word, reload the counter, go to DWELL.
  - Else, single shot: pulse done, go to IDLE, drop dds_en. fre_word holds its last value.
- Step word = 0: fre_word stays at the start word indefinitely; done never fires. This is a legal single-tone mode.
- start_word > stop_word: a single dwell at start_word, then the end-of-sweep rule applies.
- Stop in any busy state: next state = IDLE, dds_en = 0, no done pulse.
- Start and stop in the same cycle: stop wins.
- Start while busy: ignored.
- Asynchronous reset mid-sweep: immediate return to the reset values; no done pulse.

## Timing
- Start sampled at edge T: busy, dds_en and fre_word = start word are valid from edge T.
- Each word is presented for exactly cfg_dwell+1 DWELL cycles, plus 1 STEP cycle.
  - Therefore the per-word period is cfg_dwell+2 cycles.
- done is high for one cycle, coincident with the first IDLE cycle (busy low).
- Stop sampled at edge T: busy and dds_en are low from edge T.
- The DDS core's own pipeline latency is not compensated here.

## Configuration
- DDS_SWEEP_PINGPONG_EN:
  - Defined: at the upper bound the direction reverses, and the sweep steps down by step_word to the start word.
    - Single shot: done fires after the descending pass passes below start_word.
    - Continuous: the sweep bounces indefinitely.
    - Adds a direction flag register, reset value 0 (up).
  - Undefined: sawtooth behaviour only, as described in Operation.

## Structure
- Shared package dds_sweep_pkg:
  - state enum (IDLE, DWELL, STEP);
  - default widths DDS_PHASE_WIDTH = 32 and DDS_DWELL_WIDTH = 16.
- One sub-module, sweep_dwell_timer:
  - loadable down-counter of width DWELL_WIDTH with inputs load, value and en, and output expired.
  - Instantiated once.

## Test plan
- start=10, stop=40, step=10, dwell=2, single shot -> fre_word 10, 20, 30, 40, each held 4 cycles; done pulses once, 16 cycles after start; dds_en then 0.
- Same config with cfg_continuous=1 -> after 40 the sequence returns to 10 and repeats; done never asserts over 100 cycles.
- Stop asserted 5 cycles after start -> busy and dds_en low on the next edge; no done pulse; fre_word holds its value.
- start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20 -> a single dwell at 0xFFFF_FFF0, then done; fre_word never wraps to a small value.
- Start and stop asserted in the same cycle from IDLE -> busy remains 0. A second start asserted while busy -> the sequence is unchanged.
- With DDS_SWEEP_PINGPONG_EN, start=10, stop=30, step=10, dwell=0 -> fre_word 10, 20, 30, 20, 10, then done.
